pattern_tx: RTL and testbench
=============================

Name: pattern_tx

Overview:
- Serial pattern transmitter. The counterpart to the team's Moore pattern-recogniser FSMs: it generates the one-bit line stream those detectors consume.
- Captures a PAT_W-bit pattern and a repeat count on a start request. Shifts the pattern out MSB-first, one bit per clock, repeated N times. Optional zero-filled gap bits sit between repeats.
- Used as the stimulus/driver end of the serial pattern link, e.g. emitting 1101 frames into a 1101 detector.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- CNT_W, 4, width of the repeat count.
- GAP_BITS, 1, number of '0' line bits inserted between consecutive repeats (0 = back-to-back).
- DEFAULT_PAT, 4'b1101, pattern used when use_default is high at start.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst==0 resets).
- start  input  1  request to begin a transmission. Sampled only in IDLE.
- use_default  input  1  at start: 1 = send DEFAULT_PAT, 0 = send pattern.
- pattern  input  PAT_W  pattern to send, captured at start.
- repeat_n  input  CNT_W  number of repeats, captured at start.
- a  output  1  serial line bit, registered.
- bit_valid  output  1  high when a carries a transmitted bit (pattern or gap).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at end of transmission.

Behaviour:
- Reset (rst low, any time, asynchronous):
  - state=IDLE; a=0, bit_valid=0, busy=0, done=0.
  - Shift register and counters cleared.
  - Reset mid-frame abandons the frame; no done pulse.
- All outputs are Moore/registered: functions of state plus shift/count registers only, never of current inputs.
- States: IDLE, SEND, GAP, DONE. Binary encoding, 2 bits, unused codes go to IDLE.
- IDLE:
  - a=0, bit_valid=0.
  - On clk edge with start=1: capture the pattern (DEFAULT_PAT if use_default) into the shift register, repeat_n into rep_cnt, bit_cnt=PAT_W-1.
  - If repeat_n==0, go to DONE; no bits are sent.
  - Otherwise go to SEND.
- SEND:
  - a = shift register MSB, bit_valid=1.
  - Each cycle: rotate the shift register left by 1 and decrement bit_cnt.
  - When bit_cnt==0 (last bit of the pattern), decrement rep_cnt, then:
    - rep_cnt was 1: go to DONE.
    - Else if GAP_BITS>0: go to GAP with gap_cnt=GAP_BITS-1.
    - Else: stay in SEND with bit_cnt=PAT_W-1. The rotated register holds the original pattern again.
- GAP:
  - a=0, bit_valid=1.
  - Decrement gap_cnt each cycle. At gap_cnt==0, go to SEND with bit_cnt=PAT_W-1.
- DONE:
  - a=0, bit_valid=0, done=1 for exactly one cycle, then IDLE.
- Latency and length:
  - First pattern bit appears on a in the cycle after the start edge.
  - Total valid bits = R*PAT_W + (R-1)*GAP_BITS.
  - done pulses in the cycle immediately after the last valid bit.
  - busy covers SEND, GAP and DONE.
- start:
  - Ignored while busy; no queuing.
  - start held high continuously re-triggers from IDLE, i.e. one idle cycle after each done.
  - pattern, use_default and repeat_n are don't-care except at the accepted start edge.
- Maximum repeat_n = 2^CNT_W-1. Counters never wrap.

Decomposition:
- Shared package pattern_pkg:
  - State localparams (IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11).
  - Common pattern constants (PAT_1101=4'b1101). The same constants serve the detectors and this transmitter.
- One sub-module is natural: down_counter (load, dec, value, zero flag, parameterised width). It is instantiated for bit_cnt, rep_cnt and gap_cnt.
- Shift/rotate logic and the FSM stay in pattern_tx.

Test Plan:
- Reset then idle: rst low for 2 cycles, release, start=0 for 10 cycles -> a=0, bit_valid=0, busy=0, done=0 throughout.
- Single default frame: use_default=1, repeat_n=1, start pulse:
  - a = 1,1,0,1 over 4 cycles starting 1 cycle after the start edge, bit_valid=1.
  - done pulses at cycle 5; busy high cycles 1-5.
- Repeats with gap: pattern=4'b1011, repeat_n=2, GAP_BITS=1 -> a = 1,0,1,1,0,1,0,1,1 (9 valid bits), then done.
- Zero repeats and back-to-back: repeat_n=0 -> no valid bits, done 1 cycle after start. GAP_BITS=0, repeat_n=3 of 1101 -> 12 contiguous valid bits 110111011101.
- Start while busy / held start: second start pulse during SEND is ignored and the output matches a single frame. start held high gives frames separated by exactly 1 IDLE cycle.
- Reset mid-frame: assert rst low during bit 2 of 1101 -> outputs go to 0 immediately (asynchronously), no done. After release, a fresh start sends the full frame correctly.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern link: transmitter state
// encoding and the well-known frame patterns used by the detectors.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [3:0] PAT_1101 = 4'b1101;

endpackage

// File: rtl/pattern_tx_if.sv
// Request/line bundle between a pattern source (master) and the
// serial transmitter (slave).
interface pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             use_default;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             a;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, use_default, pattern, repeat_n,
        input  a, bit_valid, busy, done
    );

    modport slave (
        input  start, use_default, pattern, repeat_n,
        output a, bit_valid, busy, done
    );
endinterface

// File: rtl/pattern_tx_down_counter.sv
// Loadable down counter with a zero flag. Load has priority over
// decrement; callers gate dec with !zero so the count never wraps.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] value_reg;

    // Count register: load a new start value or step down by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_value;
        end else if (dec) begin
            value_reg <= value_reg - W'(1);
        end
    end

    assign value = value_reg;
    assign zero  = (value_reg == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first,
// repeated repeat_n times, with zero-filled gap bits between repeats.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 4,
    parameter int               GAP_BITS    = 1,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(PAT_1101)
) (
    input  logic         clk,
    input  logic         rst,
    pattern_tx_if.slave  bus
);

    localparam int               BIT_W    = $clog2(PAT_W);
    localparam int               GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;
    localparam bit               HAS_GAP  = (GAP_BITS > 0);

    state_t           state_reg;
    logic [PAT_W-1:0] shift_reg;
    logic             a_reg;
    logic             bit_valid_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [PAT_W-1:0] capture;
    logic [PAT_W-1:0] rotated;
    logic             accept;

    logic [BIT_W-1:0] bit_value;
    logic             bit_zero;
    logic [CNT_W-1:0] rep_value;
    logic             rep_zero;
    logic [GAP_W-1:0] gap_value;
    logic             gap_zero;

    logic             bit_last;
    logic             rep_last;
    logic             gap_last;
    logic             frame_end;

    assign capture  = bus.use_default ? DEFAULT_PAT : bus.pattern;
    assign rotated  = {shift_reg[PAT_W-2:0], shift_reg[PAT_W-1]};
    assign accept   = (state_reg == IDLE) && bus.start;

    assign bit_last = (bit_value == '0);
    assign gap_last = (gap_value == '0);
    // rep_zero only matters if the count was somehow exhausted; it keeps
    // the transmitter from looping forever instead of finishing.
    assign rep_last = (rep_value == CNT_W'(1)) || rep_zero;
    assign frame_end = (state_reg == SEND) && bit_last;

    // Bits remaining in the current copy of the pattern.
    down_counter #(.W(BIT_W)) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (accept
                     || (frame_end && !rep_last && !HAS_GAP)
                     || ((state_reg == GAP) && gap_last)),
        .load_value (BIT_LOAD),
        .dec        ((state_reg == SEND) && !bit_zero),
        .value      (bit_value),
        .zero       (bit_zero)
    );

    // Copies of the pattern still to be sent, including the current one.
    down_counter #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (bus.repeat_n),
        .dec        (frame_end && !rep_zero),
        .value      (rep_value),
        .zero       (rep_zero)
    );

    // Gap bits remaining before the next copy starts.
    down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (frame_end && !rep_last && HAS_GAP),
        .load_value (GAP_LOAD),
        .dec        ((state_reg == GAP) && !gap_zero),
        .value      (gap_value),
        .zero       (gap_zero)
    );

    // Control FSM with shift register and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            a_reg         <= 1'b0;
            bit_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    a_reg         <= 1'b0;
                    bit_valid_reg <= 1'b0;
                    done_reg      <= 1'b0;
                    if (bus.start) begin
                        shift_reg <= capture;
                        busy_reg  <= 1'b1;
                        if (bus.repeat_n == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= SEND;
                            a_reg         <= capture[PAT_W-1];
                            bit_valid_reg <= 1'b1;
                        end
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                SEND: begin
                    // After a full copy the rotation has restored the pattern,
                    // so rotated[MSB] is also the first bit of the next copy.
                    shift_reg <= rotated;
                    if (bit_last && rep_last) begin
                        state_reg     <= DONE;
                        a_reg         <= 1'b0;
                        bit_valid_reg <= 1'b0;
                        done_reg      <= 1'b1;
                    end else if (bit_last && HAS_GAP) begin
                        state_reg <= GAP;
                        a_reg     <= 1'b0;
                    end else begin
                        a_reg <= rotated[PAT_W-1];
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state_reg <= SEND;
                        a_reg     <= shift_reg[PAT_W-1];
                    end else begin
                        a_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    a_reg         <= 1'b0;
                    bit_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a         = a_reg;
    assign bus.bit_valid = bit_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: three instances (GAP_BITS = 0, 1, 2) share one
// stimulus stream; a stream-level model predicts each line cycle by cycle.
module tb_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int N     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             start       = 1'b0;
    logic             use_default = 1'b0;
    logic [PAT_W-1:0] pattern     = '0;
    logic [CNT_W-1:0] repeat_n    = '0;

    pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if0 ();
    pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if1 ();
    pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if2 ();

    assign if0.start = start;  assign if0.use_default = use_default;
    assign if0.pattern = pattern;  assign if0.repeat_n = repeat_n;
    assign if1.start = start;  assign if1.use_default = use_default;
    assign if1.pattern = pattern;  assign if1.repeat_n = repeat_n;
    assign if2.start = start;  assign if2.use_default = use_default;
    assign if2.pattern = pattern;  assign if2.repeat_n = repeat_n;

    pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_BITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [N-1:0] obs_a, obs_v, obs_b, obs_d;
    assign obs_a = {if2.a,         if1.a,         if0.a};
    assign obs_v = {if2.bit_valid, if1.bit_valid, if0.bit_valid};
    assign obs_b = {if2.busy,      if1.busy,      if0.busy};
    assign obs_d = {if2.done,      if1.done,      if0.done};

    // Model: per instance, the list of upcoming {a, valid, done} line slots.
    logic [2:0]   q_mem [N][256];
    int           q_len [N];
    int           q_pos [N];
    logic [N-1:0] e_a = '0, e_v = '0, e_b = '0, e_d = '0;

    logic [127:0] rec   [N];
    int           rec_n [N];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            q_len[k] = 0;
            q_pos[k] = 0;
        end
        e_a = '0; e_v = '0; e_b = '0; e_d = '0;
    endtask

    // Instance k inserts k zero gap bits between copies.
    task automatic model_step(input int k);
        logic [PAT_W-1:0] p;
        int n;
        int rn;
        if (!rst) begin
            q_len[k] = 0; q_pos[k] = 0;
            e_a[k] = 0; e_v[k] = 0; e_b[k] = 0; e_d[k] = 0;
            return;
        end
        if (!e_b[k] && start) begin
            p  = use_default ? 4'b1101 : pattern;
            rn = int'(repeat_n);
            n  = 0;
            for (int r = 0; r < rn; r++) begin
                for (int i = PAT_W - 1; i >= 0; i--) begin
                    q_mem[k][n] = {p[i], 2'b10};
                    n++;
                end
                if (r < rn - 1) begin
                    for (int g = 0; g < k; g++) begin
                        q_mem[k][n] = 3'b010;
                        n++;
                    end
                end
            end
            q_mem[k][n] = 3'b001;
            n++;
            q_len[k] = n;
            q_pos[k] = 0;
        end
        if (q_pos[k] < q_len[k]) begin
            {e_a[k], e_v[k], e_d[k]} = q_mem[k][q_pos[k]];
            e_b[k] = 1'b1;
            q_pos[k]++;
        end else begin
            e_a[k] = 0; e_v[k] = 0; e_b[k] = 0; e_d[k] = 0;
        end
    endtask

    task automatic clear_rec();
        for (int k = 0; k < N; k++) begin
            rec[k]   = '0;
            rec_n[k] = 0;
        end
    endtask

    // One clock: advance model at the edge, sample DUT 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < N; k++) model_step(k);
        #1;
        for (int k = 0; k < N; k++) begin
            if (obs_v[k] === 1'b1) begin
                rec[k] = {rec[k][126:0], obs_a[k]};
                rec_n[k]++;
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) begin
            cycle();
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        rst = 1'b1;
        repeat (10) begin
            cycle();
            if ({obs_a, obs_v, obs_b, obs_d} !== 12'b0) begin
                miscompares++;
                $display("FAIL idle cyc=%0d got a=%b v=%b b=%b d=%b want all 0",
                         cyc, obs_a, obs_v, obs_b, obs_d);
            end
            vectors++;
        end
        $display("txn reset: 2 reset cycles, 10 idle cycles");
    endtask

    task automatic test_default_frame();
        clear_rec();
        use_default = 1'b1; pattern = 4'($urandom); repeat_n = 4'd1; start = 1'b1;
        $display("txn default_frame: use_default=1 repeat_n=1");
        for (int c = 0; c < 8; c++) begin
            cycle();
            start = 1'b0;
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL default_frame cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        for (int k = 0; k < N; k++) begin
            if (rec_n[k] != 4 || rec[k][3:0] !== 4'b1101) begin
                miscompares++;
                $display("FAIL default_bits g%0d got %0d bits %b want 4 bits 1101", k, rec_n[k], rec[k][3:0]);
            end
            vectors++;
        end
    endtask

    task automatic test_gap();
        clear_rec();
        use_default = 1'b0; pattern = 4'b1011; repeat_n = 4'd2; start = 1'b1;
        $display("txn gap: pattern=1011 repeat_n=2");
        for (int c = 0; c < 14; c++) begin
            cycle();
            start = 1'b0;
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL gap cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        if (rec_n[1] != 9 || rec[1][8:0] !== 9'b101101011) begin
            miscompares++;
            $display("FAIL gap_bits_g1 got %0d bits %b want 9 bits 101101011", rec_n[1], rec[1][8:0]);
        end
        vectors++;
        if (rec_n[2] != 10 || rec[2][9:0] !== 10'b1011001011) begin
            miscompares++;
            $display("FAIL gap_bits_g2 got %0d bits %b want 10 bits 1011001011", rec_n[2], rec[2][9:0]);
        end
        vectors++;
    endtask

    task automatic test_zero_rep();
        clear_rec();
        use_default = 1'b0; pattern = 4'($urandom); repeat_n = 4'd0; start = 1'b1;
        $display("txn zero_rep: repeat_n=0");
        for (int c = 0; c < 4; c++) begin
            cycle();
            start = 1'b0;
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL zero_rep cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        if (rec_n[0] + rec_n[1] + rec_n[2] != 0) begin
            miscompares++;
            $display("FAIL zero_rep_bits got %0d valid bits want 0", rec_n[0] + rec_n[1] + rec_n[2]);
        end
        vectors++;
    endtask

    task automatic test_back_to_back();
        clear_rec();
        use_default = 1'b1; repeat_n = 4'd3; start = 1'b1;
        $display("txn back_to_back: 1101 repeat_n=3");
        for (int c = 0; c < 20; c++) begin
            cycle();
            start = 1'b0;
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        if (rec_n[0] != 12 || rec[0][11:0] !== 12'b110111011101) begin
            miscompares++;
            $display("FAIL b2b_bits_g0 got %0d bits %b want 12 bits 110111011101", rec_n[0], rec[0][11:0]);
        end
        vectors++;
    endtask

    task automatic test_start_while_busy();
        clear_rec();
        use_default = 1'b0; pattern = 4'($urandom); repeat_n = 4'd1; start = 1'b1;
        $display("txn start_while_busy: pattern=%b repeat_n=1, second start during SEND", pattern);
        for (int c = 0; c < 10; c++) begin
            cycle();
            start = (c == 1);
            pattern = 4'($urandom);
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL start_busy cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        if (rec_n[0] != 4) begin
            miscompares++;
            $display("FAIL start_busy_len got %0d valid bits want 4", rec_n[0]);
        end
        vectors++;
    endtask

    task automatic test_held_start();
        use_default = 1'b0; pattern = 4'($urandom); repeat_n = 4'd1; start = 1'b1;
        $display("txn held_start: pattern=%b repeat_n=1, start held 24 cycles", pattern);
        for (int c = 0; c < 34; c++) begin
            cycle();
            if (c == 23) start = 1'b0;
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL held_start cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
    endtask

    task automatic test_reset_mid();
        use_default = 1'b1; repeat_n = 4'd1; start = 1'b1;
        $display("txn reset_mid: 1101 aborted during bit 2");
        cycle();
        start = 1'b0;
        cycle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        if ({obs_a, obs_v, obs_b, obs_d} !== 12'b0) begin
            miscompares++;
            $display("FAIL async_reset got a=%b v=%b b=%b d=%b want all 0", obs_a, obs_v, obs_b, obs_d);
        end
        vectors++;
        repeat (2) begin
            cycle();
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        rst = 1'b1;
        clear_rec();
        start = 1'b1;
        $display("txn reset_mid_restart: 1101 repeat_n=1");
        for (int c = 0; c < 8; c++) begin
            cycle();
            start = 1'b0;
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL reset_restart cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
        if (rec_n[1] != 4 || rec[1][3:0] !== 4'b1101) begin
            miscompares++;
            $display("FAIL restart_bits got %0d bits %b want 4 bits 1101", rec_n[1], rec[1][3:0]);
        end
        vectors++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            pattern     = 4'($urandom);
            use_default = ($urandom_range(0, 3) == 0);
            repeat_n    = (t % 10 == 9) ? 4'd15 : 4'($urandom_range(0, 5));
            start       = 1'b1;
            $display("txn random %0d: pattern=%b use_default=%0b repeat_n=%0d",
                     t, pattern, use_default, repeat_n);
            for (int c = 0; c < 100; c++) begin
                cycle();
                start       = ($urandom_range(0, 7) == 0);
                pattern     = 4'($urandom);
                use_default = $urandom_range(0, 1) == 1;
                repeat_n    = 4'($urandom_range(0, 3));
                if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                    miscompares++;
                    $display("FAIL random cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                             cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
                end
                vectors++;
                if (e_b == '0 && !start) break;
            end
            start = 1'b0;
        end
        repeat (100) begin
            cycle();
            if ({obs_a, obs_v, obs_b, obs_d} !== {e_a, e_v, e_b, e_d}) begin
                miscompares++;
                $display("FAIL random_drain cyc=%0d got a=%b v=%b b=%b d=%b want a=%b v=%b b=%b d=%b",
                         cyc, obs_a, obs_v, obs_b, obs_d, e_a, e_v, e_b, e_d);
            end
            vectors++;
        end
    endtask

    initial begin
        model_reset();
        clear_rec();
        test_reset();
        test_default_frame();
        test_gap();
        test_zero_rep();
        test_back_to_back();
        test_start_while_busy();
        test_held_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
